// File: rtl/smmha_stream_alu.sv
// rtl/smmha_stream_alu.sv - multi-lane element-wise stream ALU with job FSM
// Optional saturation of ADD/SUB/RSUB/ABSDIFF results: define SMMHA_ALU_SAT_EN.
module smmha_stream_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_WIDTH*LANES-1:0]   a_tdata_i,
  input  logic [DATA_WIDTH*LANES/8-1:0] a_tstrb_i,
  input  logic                          a_tvalid_i,
  output logic                          a_tready_o,
  output logic [DATA_WIDTH*LANES-1:0]   d_tdata_o,
  output logic [DATA_WIDTH*LANES/8-1:0] d_tstrb_o,
  output logic                          d_tvalid_o,
  input  logic                          d_tready_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic [CNT_WIDTH-1:0]          len_i,
  input  logic [2:0]                    operation_i,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CNT_WIDTH-1:0]          cnt_o
);

  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                        state_q;
  logic [CNT_WIDTH-1:0]          cnt_q, len_q, cnt_d;
  logic [2:0]                    op_q;
  logic [DW-1:0]                 operand_q;
  logic                          d_valid_q;
  logic [DW*LANES-1:0]           d_data_q, data_d;
  logic [DW*LANES/8-1:0]         d_strb_q;
  logic                          in_hs;

`ifdef SMMHA_ALU_SAT_EN
  localparam logic signed [DW:0] SMAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] SMIN = {2'b11, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] sat(input logic signed [DW:0] r);
    if (r > SMAX)      return SMAX[DW-1:0];
    else if (r < SMIN) return SMIN[DW-1:0];
    else               return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] alu_lane(input logic signed [DW-1:0] a,
                                             input logic signed [DW-1:0] b,
                                             input logic [2:0] op);
    logic signed [DW:0] aw, bw;
    aw = {a[DW-1], a};
    bw = {b[DW-1], b};
    case (op)
      3'd0:    return sat(aw + bw);
      3'd1:    return sat(aw - bw);
      3'd2:    return sat(bw - aw);
      3'd3:    return (a > b) ? a : b;
      3'd4:    return (a < b) ? a : b;
      3'd5:    return sat((a > b) ? (aw - bw) : (bw - aw));
      default: return a;
    endcase
  endfunction
`else
  // Low DW bits of the wide result equal plain DW-bit arithmetic; the
  // ABSDIFF sign comes from the full signed compare.
  function automatic logic [DW-1:0] alu_lane(input logic signed [DW-1:0] a,
                                             input logic signed [DW-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return b - a;
      3'd3:    return (a > b) ? a : b;
      3'd4:    return (a < b) ? a : b;
      3'd5:    return (a > b) ? (a - b) : (b - a);
      default: return a;
    endcase
  endfunction
`endif

  always_comb begin
    data_d = '0;
    for (int k = 0; k < LANES; k++) begin
      data_d[k*DW +: DW] = alu_lane(a_tdata_i[k*DW +: DW], operand_q, op_q);
    end
  end

  assign a_tready_o = (state_q == RUN) && (!d_valid_q || d_tready_i);
  assign in_hs      = a_tvalid_i && a_tready_o;
  assign cnt_d      = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= IDLE;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
      d_strb_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      op_q      <= '0;
      operand_q <= '0;
    end else begin
      if (in_hs) begin
        d_valid_q <= 1'b1;
        d_data_q  <= data_d;
        d_strb_q  <= a_tstrb_i;
      end else if (d_tready_i) begin
        d_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q     <= len_i;
            op_q      <= operation_i;
            operand_q <= operand_i;
            cnt_q     <= '0;
            state_q   <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_hs) begin
            cnt_q <= cnt_d;
            if (cnt_d == len_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!d_valid_q || d_tready_i) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_tdata_o  = d_data_q;
  assign d_tstrb_o  = d_strb_q;
  assign d_tvalid_o = d_valid_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_smmha_stream_alu.sv
// tb/tb_smmha_stream_alu.sv - directed table-driven bench for smmha_stream_alu
// Expected saturation results follow SMMHA_ALU_SAT_EN.
module tb_smmha_stream_alu;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  a_tdata;
  logic [15:0]   a_tstrb;
  logic          a_tvalid;
  logic          a_tready;
  logic [127:0]  d_tdata;
  logic [15:0]   d_tstrb;
  logic          d_tvalid;
  logic          d_tready;
  logic          start, clear;
  logic [15:0]   len;
  logic [2:0]    op;
  logic [31:0]   operand;
  logic          busy, done;
  logic [15:0]   cnt;

`ifdef SMMHA_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  smmha_stream_alu dut (
    .clk_i(clk), .rst_i(rst),
    .a_tdata_i(a_tdata), .a_tstrb_i(a_tstrb), .a_tvalid_i(a_tvalid), .a_tready_o(a_tready),
    .d_tdata_o(d_tdata), .d_tstrb_o(d_tstrb), .d_tvalid_o(d_tvalid), .d_tready_i(d_tready),
    .start_i(start), .clear_i(clear), .len_i(len), .operation_i(op), .operand_i(operand),
    .busy_o(busy), .done_o(done), .cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int in_hs = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [143:0] outq[$];
  int outcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_tvalid && d_tready) begin
      outq.push_back({d_tstrb, d_tdata});
      outcyc.push_back(cyc);
    end
    if (a_tvalid && a_tready) in_hs++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]   op;
    logic [31:0]  b;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [127:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] l, input logic [2:0] o, input logic [31:0] b);
    start = 1'b1; len = l; op = o; operand = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d);
    bit hs = 1'b0;
    a_tvalid = 1'b1;
    a_tdata  = d;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      if (a_tready) hs = 1'b1;
      tick();
    end
    if (!hs) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    int dcnt0, in0;
    logic [127:0] held;
    bit stable, rdy0, got;

    rst = 1'b1; clear = 1'b0; start = 1'b0; len = '0; op = '0; operand = '0;
    a_tdata = '0; a_tstrb = 16'hFFFF; a_tvalid = 1'b1; d_tready = 1'b1;

    vecs[0]  = '{3'd3, 32'd2, pk(-3, 7, 0, -8), pk(2, 7, 2, 2)};
    vecs[1]  = '{3'd4, 32'd2, pk(-3, 7, 0, -8), pk(-3, 2, 0, -8)};
    vecs[2]  = '{3'd5, 32'd2, pk(-3, 7, 0, -8), pk(5, 5, 2, 10)};
    vecs[3]  = '{3'd2, 32'd2, pk(-3, 7, 0, -8), pk(5, -5, 2, 10)};
    vecs[4]  = '{3'd1, 32'd2, pk(-3, 7, 0, -8), pk(-5, 5, -2, -10)};
    vecs[5]  = '{3'd0, 32'd2, pk(-3, 7, 0, -8), pk(-1, 9, 2, -6)};
    vecs[6]  = '{3'd6, 32'd2, pk(-3, 7, 0, -8), pk(-3, 7, 0, -8)};
    vecs[7]  = '{3'd7, 32'd2, pk(-3, 7, 0, -8), pk(-3, 7, 0, -8)};
    vecs[8]  = '{3'd0, 32'h7FFFFFFF, pk(1, 0, -1, 32'h80000000),
                 pk(SAT ? 32'h7FFFFFFF : 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFE, 32'hFFFFFFFF)};
    vecs[9]  = '{3'd1, 32'd1, pk(32'h80000000, 0, 5, 32'h7FFFFFFF),
                 pk(SAT ? 32'h80000000 : 32'h7FFFFFFF, -1, 4, 32'h7FFFFFFE)};
    vecs[10] = '{3'd5, 32'h7FFFFFFF, pk(32'h80000000, 32'h7FFFFFFF, 0, -1),
                 pk(SAT ? 32'h7FFFFFFF : 32'hFFFFFFFF, 0, 32'h7FFFFFFF,
                    SAT ? 32'h7FFFFFFF : 32'h80000000)};
    vecs[11] = '{3'd2, 32'h80000000, pk(1, 0, -1, 32'h80000000),
                 pk(SAT ? 32'h80000000 : 32'h7FFFFFFF, 32'h80000000, 32'h80000001, 0)};

    repeat (3) tick();
    chk("rst_dvalid", d_tvalid, 0);
    chk("rst_ddata", d_tdata, 0);
    chk("rst_dstrb", d_tstrb, 0);
    chk("rst_aready", a_tready, 0);
    chk("rst_flags", {busy, done, cnt}, 0);
    rst = 1'b0;
    a_tvalid = 1'b0;
    tick();

    // Table: one single-beat job per vector
    for (int i = 0; i < 12; i++) begin
      outq.delete();
      a_tstrb = 16'hFFFF;
      start_job(16'd1, vecs[i].op, vecs[i].b);
      send_beat(vecs[i].din);
      a_tvalid = 1'b0;
      wait_done($sformatf("vec%0d_done", i));
      tick();
      chk($sformatf("vec%0d_count", i), outq.size(), 1);
      if (outq.size() > 0) chk($sformatf("vec%0d_data", i), outq[0], {16'hFFFF, vecs[i].exp});
    end

    // Basic ADD, 3 beats back to back
    outq.delete(); outcyc.delete();
    dcnt0 = done_cnt;
    a_tstrb = 16'hA5C3;
    start_job(16'd3, 3'd0, 32'd5);
    for (int i = 0; i < 3; i++) send_beat(pk(1, -2, 100, 0));
    a_tvalid = 1'b0;
    wait_done("add_done");
    tick();
    chk("add_count", outq.size(), 3);
    for (int i = 0; i < outq.size(); i++)
      chk($sformatf("add_beat%0d", i), outq[i], {16'hA5C3, pk(6, 3, 105, 5)});
    if (outcyc.size() == 3) begin
      chk("add_throughput", outcyc[2] - outcyc[0], 2);
      chk("add_done_timing", done_cyc, outcyc[2] + 1);
    end
    chk("add_done_pulse", {done, 32'(done_cnt - dcnt0)}, {1'b0, 32'd1});
    tick();
    chk("add_cnt_hold", cnt, 3);

    // Backpressure: SUB, stalled output for several cycles
    outq.delete();
    a_tstrb = 16'hFFFF;
    d_tready = 1'b0;
    start_job(16'd4, 3'd1, 32'd1);
    held = '0; stable = 1'b1; rdy0 = 1'b1; got = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat(pk(10*i+1, 10*i+2, 10*i+3, 10*i+4));
        a_tvalid = 1'b0;
      end
      begin
        for (int i = 0; i < 20 && !got; i++) begin
          @(negedge clk);
          if (d_tvalid) got = 1'b1;
        end
        held = d_tdata;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (d_tdata !== held) stable = 1'b0;
          if (a_tready !== 1'b0) rdy0 = 1'b0;
        end
        @(posedge clk);
        #1 d_tready = 1'b1;
      end
    join
    chk("bp_first_valid", got, 1);
    chk("bp_first_data", held, pk(0, 1, 2, 3));
    chk("bp_stable", stable, 1);
    chk("bp_aready_low", rdy0, 1);
    wait_done("bp_done");
    tick();
    chk("bp_count", outq.size(), 4);
    for (int i = 0; i < outq.size(); i++)
      chk($sformatf("bp_beat%0d", i), outq[i], {16'hFFFF, pk(10*i, 10*i+1, 10*i+2, 10*i+3)});
    chk("bp_cnt", cnt, 4);

    // len == 0: immediate done, nothing consumed
    in0 = in_hs;
    a_tvalid = 1'b1;
    a_tdata = pk(9, 9, 9, 9);
    start_job(16'd0, 3'd0, 32'd0);
    chk("len0_done", {done, busy, cnt}, {1'b1, 1'b1, 16'd0});
    chk("len0_aready", a_tready, 0);
    tick();
    chk("len0_after", {done, busy}, 0);
    a_tvalid = 1'b0;
    tick();
    chk("len0_no_input", in_hs, in0);

    // start during RUN is ignored
    outq.delete();
    start_job(16'd2, 3'd0, 32'd5);
    send_beat(pk(1, 2, 3, 4));
    a_tvalid = 1'b0;
    start_job(16'd7, 3'd1, 32'd100);
    send_beat(pk(10, 20, 30, 40));
    a_tvalid = 1'b0;
    wait_done("ign_done");
    tick();
    chk("ign_count", outq.size(), 2);
    if (outq.size() == 2) begin
      chk("ign_beat0", outq[0], {16'hFFFF, pk(6, 7, 8, 9)});
      chk("ign_beat1", outq[1], {16'hFFFF, pk(15, 25, 35, 45)});
    end
    chk("ign_cnt", cnt, 2);

    // clear mid-job with an output beat pending
    dcnt0 = done_cnt;
    start_job(16'd5, 3'd0, 32'd1);
    send_beat(pk(1, 1, 1, 1));
    send_beat(pk(2, 2, 2, 2));
    a_tvalid = 1'b0;
    d_tready = 1'b0;
    chk("clr_pending", {d_tvalid, cnt}, {1'b1, 16'd2});
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_state", {d_tvalid, busy, cnt}, 0);
    chk("clr_data", {d_tstrb, d_tdata}, 0);
    repeat (5) tick();
    chk("clr_no_done", done_cnt, dcnt0);
    d_tready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
